encode: RTL and testbench

Instruction encoder and issue buffer that sits upstream of `decode`. It accepts R-type instruction fields over a valid/ready handshake and packs them into the 32-bit instruction word that `decode` consumes. Each packed word goes into a small FIFO, which presents words one per cycle on a valid/ready output to the decode/execute stage. It also keeps a running count of issued words.

---
 rtl/encode.sv | 96 +++++++++
 tb/tb_encode.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/encode.sv
// R-type instruction encoder feeding a DEPTH-entry issue FIFO with a popped-word counter.
// Optional field legality check (drop + err pulse) is enabled by defining ENCODE_CHECK_EN.
module encode #(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               funct7,
  input  logic [4:0]               rs2,
  input  logic [4:0]               rs1,
  input  logic [2:0]               funct3,
  input  logic [4:0]               rd,
  input  logic [6:0]               op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              opcode,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CW-1:0]            issued,
  output logic                     err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds data stable while valid && !ready; ready never depends on valid.
  logic [31:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic [CW-1:0]   r_issued;

  logic [31:0]     w_word;
  logic            w_legal;
  logic            w_push;
  logic            w_write;
  logic            w_pop;

  assign w_word    = {funct7, rs2, rs1, funct3, rd, op};
  assign in_ready  = (r_count != CNTW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_write   = w_push && w_legal;
  assign opcode    = out_valid ? r_mem[r_rd_ptr] : 32'h0;
  assign count     = r_count;
  assign issued    = r_issued;

`ifdef ENCODE_CHECK_EN
  logic r_err;

  // Only plain R-type ALU ops (ADD-class or SUB/SRA-class funct7) are legal.
  assign w_legal = (op == 7'h33) && ((funct7 == 7'h00) || (funct7 == 7'h20));
  assign err     = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_push && !w_legal;
    end
  end
`else
  assign w_legal = 1'b1;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_issued <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_issued <= r_issued + CW'(1);
      end
      r_count <= r_count + CNTW'(w_write) - CNTW'(w_pop);
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

endmodule

// File: tb/tb_encode.sv
// Directed bench for encode: vector table for packing, hand sequences for
// backpressure, streaming, async reset and the ENCODE_CHECK_EN drop path.
module tb_encode;

  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  funct7;
  logic [4:0]  rs2;
  logic [4:0]  rs1;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [6:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] opcode;
  logic [2:0]  count;
  logic [CW-1:0] issued;
  logic        err;

  encode #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct7    (funct7),
    .rs2       (rs2),
    .rs1       (rs1),
    .funct3    (funct3),
    .rd        (rd),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .opcode    (opcode),
    .count     (count),
    .issued    (issued),
    .err       (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  funct7;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] exp_q [$];
  int          n_vec;
  int          n_err;
  int          exp_issued;
  int          model_count;
  logic [31:0] w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_fields(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                              input logic [2:0] f3, input logic [4:0] d, input logic [6:0] o);
    funct7 = f7; rs2 = r2; rs1 = r1; funct3 = f3; rd = d; op = o;
  endtask

  // distinct legal word per index, expected value formed from field positions
  task automatic drive_idx(input int k, output logic [31:0] word);
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] c;
    a = 5'(k + 1);
    b = 5'(k * 3 + 2);
    c = 5'(31 - k);
    drive_fields((k % 2 == 1) ? 7'h20 : 7'h00, a, b, 3'(k), c, 7'h33);
    word = {((k % 2 == 1) ? 7'h20 : 7'h00), a, b, 3'(k), c, 7'h33};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_issued = 0;
    model_count = 0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_issued = 0; model_count = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive_fields(7'h0, 5'h0, 5'h0, 3'h0, 5'h0, 7'h0);

    vecs[0] = '{7'h00, 5'd2,  5'd1,  3'd0, 5'd3,  7'h33, 32'h002081B3};
    vecs[1] = '{7'h20, 5'd7,  5'd6,  3'd0, 5'd5,  7'h33, 32'h407302B3};
    vecs[2] = '{7'h00, 5'd0,  5'd0,  3'd0, 5'd0,  7'h33, 32'h00000033};
    vecs[3] = '{7'h20, 5'h1F, 5'h1F, 3'd7, 5'h1F, 7'h33, 32'h41FFFFB3};
    vecs[4] = '{7'h00, 5'h0A, 5'h15, 3'd5, 5'h11, 7'h33, 32'h00AAD8B3};
    vecs[5] = '{7'h20, 5'h13, 5'h0C, 3'd2, 5'h1E, 7'h33, 32'h41362F33};

    // reset state, asserted from time zero
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h1);
    check("rst_count",     32'(count),     32'h0);
    check("rst_opcode",    opcode,         32'h0);
    check("rst_issued",    32'(issued),    32'h0);
    check("rst_err",       32'(err),       32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // table: push one, see it next cycle, pop it
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_fields(vecs[i].funct7, vecs[i].rs2, vecs[i].rs1, vecs[i].funct3, vecs[i].rd, vecs[i].op);
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'h1);
      check($sformatf("vec%0d_count", i), 32'(count), 32'h1);
      check($sformatf("vec%0d_opcode", i), opcode, vecs[i].exp);
      check($sformatf("vec%0d_err", i), 32'(err), 32'h0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      exp_issued++;
      check($sformatf("vec%0d_issued", i), 32'(issued), 32'(exp_issued));
      check($sformatf("vec%0d_empty", i), 32'(count), 32'h0);
      check($sformatf("vec%0d_opcode0", i), opcode, 32'h0);
    end

    // fill with backpressure: 6 cycles of in_valid, only DEPTH accepted
    begin
      int k;
      k = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        check($sformatf("fill%0d_in_ready", c), 32'(in_ready), 32'(model_count != DEPTH));
        drive_idx(k, w);
        in_valid = 1'b1;
        if (model_count != DEPTH) begin
          exp_q.push_back(w);
          model_count++;
          k++;
        end
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("fill_count", 32'(count), 32'(DEPTH));
      check("fill_in_ready", 32'(in_ready), 32'h0);
      check("fill_accepted", 32'(k), 32'(DEPTH));
      out_ready = 1'b1;
      for (int c = 0; c < DEPTH; c++) begin
        check($sformatf("drain%0d_valid", c), 32'(out_valid), 32'h1);
        check($sformatf("drain%0d_opcode", c), opcode, exp_q.pop_front());
        @(negedge clk);
      end
      out_ready = 1'b0;
      check("drain_count", 32'(count), 32'h0);
      check("drain_valid", 32'(out_valid), 32'h0);
    end

    // streaming: push+pop every cycle for 20 words from a fresh reset
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("stream%0d_count", i), 32'(count), 32'h1);
        check($sformatf("stream%0d_opcode", i), opcode, exp_q.pop_front());
      end
      drive_idx(i + 7, w);
      exp_q.push_back(w);
      in_valid = 1'b1;
      out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("stream_last_count", 32'(count), 32'h1);
    check("stream_last_opcode", opcode, exp_q.pop_front());
    @(negedge clk);
    out_ready = 1'b0;
    check("stream_end_count", 32'(count), 32'h0);
    check("stream_issued", 32'(issued), 32'd20);

    // async reset mid-operation with three words buffered
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_idx(i + 40, w);
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_count", 32'(count), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'h0);
    check("async_count", 32'(count), 32'h0);
    check("async_opcode", opcode, 32'h0);
    check("async_in_ready", 32'(in_ready), 32'h1);
    check("async_issued", 32'(issued), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_fields(7'h20, 5'd7, 5'd6, 3'd0, 5'd5, 7'h33);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_count", 32'(count), 32'h1);
    check("post_rst_opcode", opcode, 32'h407302B3);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_rst_issued", 32'(issued), 32'h1);

    // illegal op (I-type 0x13): dropped with err when checking is built in
    @(negedge clk);
    drive_fields(7'h00, 5'd4, 5'd3, 3'd0, 5'd2, 7'h13);
    in_valid = 1'b1;
    check("chk_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
`ifdef ENCODE_CHECK_EN
    check("chk_err", 32'(err), 32'h1);
    check("chk_count", 32'(count), 32'h0);
    check("chk_opcode", opcode, 32'h0);
`else
    check("chk_err", 32'(err), 32'h0);
    check("chk_count", 32'(count), 32'h1);
    check("chk_opcode", opcode, 32'h00418113);
`endif
    @(negedge clk);
    check("chk_err_clear", 32'(err), 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("chk_final_count", 32'(count), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
